// File: rtl/shared_data_memory_responder.sv
// ---------------------------------------------------------------------------
// shared_data_memory_responder
//
// Memory-side responder shared by the MEM stages of two cores. One
// word-addressed array of 2**ADDR_W 32-bit words is granted round-robin to
// core 0 and core 1. Each access takes three cycles:
//   IDLE (request seen, winner latched) -> BUSY (array access) -> DONE.
// Stores write byte/half/word lanes under a lane mask. Loads return the
// selected lane(s) zero-extended.
//
// Parameters
//   ADDR_W    word-address bits; the array holds 2**ADDR_W words
//   MEM_INIT  preload image name for implementation flows that initialise
//             the array from a file; the array has no reset and is never
//             cleared by Reset
//
// Ports (n = 0, 1)
//   Clk              clock, all state changes on the rising edge
//   Reset            synchronous, active-high; aborts an in-flight access
//   Cn_MemRead       core n load request
//   Cn_MemWrite      core n store request (wins over MemRead)
//   Cn_HalfControl   core n half-word access
//   Cn_ByteControl   core n byte access (wins over HalfControl)
//   Cn_Address       core n byte address
//   Cn_WriteData     core n store data, sub-word data in the low bits
//   Cn_ReadData      core n load result, held until core n's next load Done
//   Cn_Done          one-cycle pulse when core n's access completes
//   Cn_Stall         (Cn_MemRead | Cn_MemWrite) & ~Cn_Done
//   dbg_state_o      current FSM state (0 IDLE, 1 BUSY, 2 DONE)
//
// Handshake: a core raises MemRead/MemWrite and holds request, address, data
// and controls stable while its Stall is 1. In the cycle its Done is 1 the
// Stall is 0, and the core advances on the following rising edge.
// ---------------------------------------------------------------------------
module shared_data_memory_responder #(
  parameter int ADDR_W   = 10,
  parameter     MEM_INIT = ""
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        C0_MemRead,
  input  logic        C0_MemWrite,
  input  logic        C0_HalfControl,
  input  logic        C0_ByteControl,
  input  logic [31:0] C0_Address,
  input  logic [31:0] C0_WriteData,
  output logic [31:0] C0_ReadData,
  output logic        C0_Done,
  output logic        C0_Stall,
  input  logic        C1_MemRead,
  input  logic        C1_MemWrite,
  input  logic        C1_HalfControl,
  input  logic        C1_ByteControl,
  input  logic [31:0] C1_Address,
  input  logic [31:0] C1_WriteData,
  output logic [31:0] C1_ReadData,
  output logic        C1_Done,
  output logic        C1_Stall,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              win_q, win_d;     // core owning the current access
  logic              ptr_q, ptr_d;     // core that wins a simultaneous request
  logic              wr_q, wr_d;
  logic              half_q, half_d;
  logic              byte_q, byte_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;

  logic [31:0]       mem_q [2**ADDR_W];

  logic              req0, req1, grant;
  logic [ADDR_W-1:0] idx;
  logic [31:0]       word;
  logic [31:0]       load_val;
  logic [3:0]        wmask;
  logic [31:0]       wlanes;

  // Address bits above the array size only alias; they are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{C0_Address[31:ADDR_W+2], C1_Address[31:ADDR_W+2]};

  assign req0  = C0_MemRead | C0_MemWrite;
  assign req1  = C1_MemRead | C1_MemWrite;
  // A lone requester wins outright; on a tie the round-robin pointer decides.
  assign grant = (req0 & req1) ? ptr_q : req1;

  assign idx  = addr_q[ADDR_W+1:2];
  assign word = mem_q[idx];

  // Load lane extraction, zero-extended. Byte select beats half select.
  always_comb begin
    load_val = word;
    if (byte_q) begin
      case (addr_q[1:0])
        2'd0:    load_val = {24'b0, word[7:0]};
        2'd1:    load_val = {24'b0, word[15:8]};
        2'd2:    load_val = {24'b0, word[23:16]};
        default: load_val = {24'b0, word[31:24]};
      endcase
    end else if (half_q) begin
      load_val = addr_q[1] ? {16'b0, word[31:16]} : {16'b0, word[15:0]};
    end
  end

  // Store lanes: sub-word data is replicated across lanes so the mask alone
  // picks where it lands.
  always_comb begin
    wmask  = 4'b1111;
    wlanes = wdata_q;
    if (byte_q) begin
      wmask  = 4'b0001 << addr_q[1:0];
      wlanes = {4{wdata_q[7:0]}};
    end else if (half_q) begin
      wmask  = addr_q[1] ? 4'b1100 : 4'b0011;
      wlanes = {2{wdata_q[15:0]}};
    end
  end

  // Next-state and datapath latching.
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    ptr_d    = ptr_q;
    wr_d     = wr_q;
    half_d   = half_q;
    byte_d   = byte_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (req0 | req1) begin
          win_d   = grant;
          wr_d    = grant ? C1_MemWrite    : C0_MemWrite;
          half_d  = grant ? C1_HalfControl : C0_HalfControl;
          byte_d  = grant ? C1_ByteControl : C0_ByteControl;
          addr_d  = grant ? C1_Address[ADDR_W+1:0] : C0_Address[ADDR_W+1:0];
          wdata_d = grant ? C1_WriteData   : C0_WriteData;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Load result is captured here so it is already valid during DONE.
        if (!wr_q) begin
          if (win_q) rdata1_d = load_val;
          else       rdata0_d = load_val;
        end
        state_d = ST_DONE;
      end
      ST_DONE: begin
        ptr_d   = ~win_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= ST_IDLE;
      win_q    <= 1'b0;
      ptr_q    <= 1'b0;
      wr_q     <= 1'b0;
      half_q   <= 1'b0;
      byte_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      ptr_q    <= ptr_d;
      wr_q     <= wr_d;
      half_q   <= half_d;
      byte_q   <= byte_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // Array write at the end of BUSY. Reset suppresses it so an aborted store
  // leaves the word untouched; the array contents themselves are not reset.
  always_ff @(posedge Clk) begin
    if (!Reset && state_q == ST_BUSY && wr_q) begin
      for (int k = 0; k < 4; k++) begin
        if (wmask[k]) mem_q[idx][8*k +: 8] <= wlanes[8*k +: 8];
      end
    end
  end

  assign C0_Done     = (state_q == ST_DONE) & ~win_q;
  assign C1_Done     = (state_q == ST_DONE) &  win_q;
  assign C0_Stall    = req0 & ~C0_Done;
  assign C1_Stall    = req1 & ~C1_Done;
  assign C0_ReadData = rdata0_q;
  assign C1_ReadData = rdata1_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shared_data_memory_responder.sv
module tb_shared_data_memory_responder;

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  always #5 Clk = ~Clk;
  logic Reset;

  logic [1:0]       rd_r, wr_r, hc_r, bc_r;
  logic [1:0][31:0] addr_r, wd_r;
  logic [1:0][31:0] rdata_o;
  logic [1:0]       done_o, stall_o;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int pref;                 // core that wins the next simultaneous request
  logic [7:0] mb [4096];    // byte-addressed reference memory (4 KiB aliases)

  shared_data_memory_responder #(.ADDR_W(10), .MEM_INIT("")) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .C0_MemRead     (rd_r[0]),
    .C0_MemWrite    (wr_r[0]),
    .C0_HalfControl (hc_r[0]),
    .C0_ByteControl (bc_r[0]),
    .C0_Address     (addr_r[0]),
    .C0_WriteData   (wd_r[0]),
    .C0_ReadData    (rdata_o[0]),
    .C0_Done        (done_o[0]),
    .C0_Stall       (stall_o[0]),
    .C1_MemRead     (rd_r[1]),
    .C1_MemWrite    (wr_r[1]),
    .C1_HalfControl (hc_r[1]),
    .C1_ByteControl (bc_r[1]),
    .C1_Address     (addr_r[1]),
    .C1_WriteData   (wd_r[1]),
    .C1_ReadData    (rdata_o[1]),
    .C1_Done        (done_o[1]),
    .C1_Stall       (stall_o[1]),
    .dbg_state_o    (dbg_state)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int acc_bytes(input logic hc, input logic bc);
    return bc ? 1 : (hc ? 2 : 4);
  endfunction

  function automatic void m_store(input logic [31:0] a, input int n, input logic [31:0] d);
    int base;
    base = int'(a[11:0]) & ~(n - 1);
    for (int i = 0; i < n; i++) mb[base + i] = d[8*i +: 8];
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input int n);
    int base;
    logic [31:0] r;
    base = int'(a[11:0]) & ~(n - 1);
    r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = mb[base + i];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_core(input int c);
    rd_r[c] = 1'b0; wr_r[c] = 1'b0; hc_r[c] = 1'b0; bc_r[c] = 1'b0;
    addr_r[c] = '0; wd_r[c] = '0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    clear_core(0);
    clear_core(1);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    pref = 0;
  endtask

  // Starts just after a rising edge (cycle 0); returns just after the edge
  // that ends the Done cycle. lat = cycle of Done (-1 on timeout),
  // stall_cyc = cycles in which Stall was seen high.
  task automatic core_access(input int c, input logic rdb, input logic wrb,
                             input logic hc, input logic bc,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rdv, output int lat,
                             output int stall_cyc);
    rd_r[c] = rdb; wr_r[c] = wrb; hc_r[c] = hc; bc_r[c] = bc;
    addr_r[c] = a; wd_r[c] = d;
    lat = -1; stall_cyc = 0; rdv = '0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (stall_o[c]) stall_cyc++;
      if (done_o[c]) begin
        lat = k;
        rdv = rdata_o[c];
        break;
      end
    end
    @(posedge Clk);
    #1 clear_core(c);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int lat;
    Reset = 1'b1;
    rd_r[0] = 1'b1; addr_r[0] = 32'h40;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    n_checks++; if (stall_o[0] !== 1'b1) begin n_fail++; $display("FAIL reset_stall: got %b expected 1", stall_o[0]); end
    n_checks++; if (done_o !== 2'b00) begin n_fail++; $display("FAIL reset_done: got %b expected 00", done_o); end
    n_checks++; if (rdata_o[0] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata0: got %h expected 0", rdata_o[0]); end
    n_checks++; if (rdata_o[1] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata1: got %h expected 0", rdata_o[1]); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    @(posedge Clk);
    #1 Reset = 1'b0;
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      if (done_o[0]) begin lat = k; break; end
    end
    @(posedge Clk);
    #1 rd_r[0] = 1'b0;
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL reset_release_latency: got %0d expected 2", lat); end
    pref = 1;
  endtask

  task automatic test_word();
    logic [31:0] v; int lat, sc;
    core_access(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10, 32'hDEADBEEF, v, lat, sc);
    m_store(32'h10, 4, 32'hDEADBEEF); pref = 1;
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL sw_latency: got %0d expected 2", lat); end
    core_access(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, v, lat, sc);
    pref = 1;
    n_checks++; if (v !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h expected deadbeef", v); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL lw_latency: got %0d expected 2", lat); end
    n_checks++; if (sc != 2) begin n_fail++; $display("FAIL lw_stall_cycles: got %0d expected 2", sc); end
  endtask

  task automatic test_subword();
    logic [31:0] v; int lat, sc;
    core_access(0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h11, 32'hFFFFFF55, v, lat, sc);
    m_store(32'h11, 1, 32'hFFFFFF55);
    core_access(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, v, lat, sc);
    n_checks++; if (v !== 32'hDEAD55EF) begin n_fail++; $display("FAIL sb_word: got %h expected dead55ef", v); end
    core_access(0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h13, 32'h0, v, lat, sc);
    n_checks++; if (v !== 32'h000000DE) begin n_fail++; $display("FAIL lb_data: got %h expected 000000de", v); end
    core_access(0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h12, 32'hABCD1234, v, lat, sc);
    m_store(32'h12, 2, 32'hABCD1234);
    n_checks++; if (rdata_o[0] !== 32'h000000DE) begin n_fail++; $display("FAIL store_keeps_rdata: got %h expected 000000de", rdata_o[0]); end
    core_access(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, v, lat, sc);
    n_checks++; if (v !== 32'h123455EF) begin n_fail++; $display("FAIL sh_word: got %h expected 123455ef", v); end
    core_access(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0, v, lat, sc);
    n_checks++; if (v !== 32'h000055EF) begin n_fail++; $display("FAIL lh_data: got %h expected 000055ef", v); end
    // Byte control wins over half control: lane 2 of 0x123455EF.
    core_access(0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h12, 32'h0, v, lat, sc);
    n_checks++; if (v !== 32'h00000034) begin n_fail++; $display("FAIL byte_over_half: got %h expected 00000034", v); end
    pref = 1;
  endtask

  task automatic test_collision();
    logic [31:0] va, vb, vc; int la, lb, lc, sa, sb, sc;
    do_reset();
    fork
      begin
        core_access(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, va, la, sa);
        core_access(0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h12, 32'h0, vb, lb, sb);
      end
      core_access(1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h13, 32'h0, vc, lc, sc);
    join
    n_checks++; if (la != 2) begin n_fail++; $display("FAIL coll_c0_latency: got %0d expected 2", la); end
    n_checks++; if (va !== 32'h123455EF) begin n_fail++; $display("FAIL coll_c0_data: got %h expected 123455ef", va); end
    n_checks++; if (lc != 5) begin n_fail++; $display("FAIL coll_c1_latency: got %0d expected 5", lc); end
    n_checks++; if (vc !== 32'h00000012) begin n_fail++; $display("FAIL coll_c1_data: got %h expected 00000012", vc); end
    n_checks++; if (lb != 5) begin n_fail++; $display("FAIL coll_c0_second_latency: got %0d expected 5", lb); end
    n_checks++; if (vb !== 32'h00001234) begin n_fail++; $display("FAIL coll_c0_second_data: got %h expected 00001234", vb); end
    pref = 1;
  endtask

  task automatic test_rr_store_load();
    logic [31:0] v0, v1; int l0, l1, s0, s1;
    fork
      core_access(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h1020, 32'h0, v0, l0, s0);
      core_access(1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'hCAFEF00D, v1, l1, s1);
    join
    m_store(32'h20, 4, 32'hCAFEF00D);
    pref = 1;
    n_checks++; if (l1 != 2) begin n_fail++; $display("FAIL rr_c1_latency: got %0d expected 2", l1); end
    n_checks++; if (l0 != 5) begin n_fail++; $display("FAIL rr_c0_latency: got %0d expected 5", l0); end
    n_checks++; if (v0 !== 32'hCAFEF00D) begin n_fail++; $display("FAIL rr_alias_load: got %h expected cafef00d", v0); end
  endtask

  task automatic test_reset_abort();
    logic [31:0] v; int lat, sc, dones;
    core_access(0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h22222222, v, lat, sc);
    m_store(32'h30, 4, 32'h22222222);
    rd_r[0] = 1'b0; wr_r[0] = 1'b1; addr_r[0] = 32'h30; wd_r[0] = 32'h11111111;
    @(posedge Clk);
    #1 Reset = 1'b1;   // access is now in BUSY
    clear_core(0);
    dones = 0;
    repeat (3) begin
      @(negedge Clk);
      if (done_o != 2'b00) dones++;
    end
    @(posedge Clk);
    #1 Reset = 1'b0;
    pref = 0;
    n_checks++; if (dones != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d done cycles expected 0", dones); end
    core_access(0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h30, 32'h0, v, lat, sc);
    pref = 1;
    n_checks++; if (v !== 32'h22222222) begin n_fail++; $display("FAIL abort_word_unchanged: got %h expected 22222222", v); end
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom();
    return {r[31:12], 12'h100 + 12'($urandom_range(0, 63))};
  endfunction

  task automatic test_random_single();
    logic [31:0] v, a, d, e; int lat, sc, c, n;
    logic rdb, wrb, hc, bc;
    for (int w = 0; w < 16; w++) begin
      d = $urandom();
      c = w % 2;
      core_access(c, 1'b0, 1'b1, 1'b0, 1'b0, 32'h100 + 32'(4*w), d, v, lat, sc);
      m_store(32'h100 + 32'(4*w), 4, d);
      pref = 1 - c;
    end
    for (int i = 0; i < 80; i++) begin
      c = $urandom_range(0, 1);
      wrb = 1'($urandom_range(0, 1));
      rdb = wrb ? 1'($urandom_range(0, 1)) : 1'b1;
      hc = ($urandom_range(0, 2) == 0);
      bc = ($urandom_range(0, 2) == 0);
      a = rand_addr();
      d = $urandom();
      n = acc_bytes(hc, bc);
      e = m_load(a, n);
      core_access(c, rdb, wrb, hc, bc, a, d, v, lat, sc);
      pref = 1 - c;
      if (wrb) m_store(a, n, d);
      n_checks++; if (lat != 2 || sc != 2) begin n_fail++; $display("FAIL rand_timing[%0d]: got lat %0d stall %0d expected 2 2", i, lat, sc); end
      if (!wrb) begin
        n_checks++; if (v !== e) begin n_fail++; $display("FAIL rand_load[%0d]: got %h expected %h", i, v, e); end
      end
    end
  endtask

  task automatic test_random_dual();
    logic [1:0] rdb, wrb, hc, bc;
    logic [1:0][31:0] a, d, v, e;
    int lat[2], sc[2], n[2];
    int win, los;
    for (int i = 0; i < 30; i++) begin
      for (int c = 0; c < 2; c++) begin
        wrb[c] = 1'($urandom_range(0, 1));
        rdb[c] = wrb[c] ? 1'($urandom_range(0, 1)) : 1'b1;
        hc[c] = ($urandom_range(0, 2) == 0);
        bc[c] = ($urandom_range(0, 2) == 0);
        a[c] = rand_addr();
        d[c] = $urandom();
        n[c] = acc_bytes(hc[c], bc[c]);
      end
      win = pref; los = 1 - pref;
      e[win] = m_load(a[win], n[win]);
      if (wrb[win]) m_store(a[win], n[win], d[win]);
      e[los] = m_load(a[los], n[los]);
      if (wrb[los]) m_store(a[los], n[los], d[los]);
      pref = win;
      fork
        core_access(0, rdb[0], wrb[0], hc[0], bc[0], a[0], d[0], v[0], lat[0], sc[0]);
        core_access(1, rdb[1], wrb[1], hc[1], bc[1], a[1], d[1], v[1], lat[1], sc[1]);
      join
      n_checks++; if (lat[win] != 2) begin n_fail++; $display("FAIL dual_winner_latency[%0d]: got %0d expected 2", i, lat[win]); end
      n_checks++; if (lat[los] != 5) begin n_fail++; $display("FAIL dual_loser_latency[%0d]: got %0d expected 5", i, lat[los]); end
      for (int c = 0; c < 2; c++) begin
        if (!wrb[c]) begin
          n_checks++; if (v[c] !== e[c]) begin n_fail++; $display("FAIL dual_load_c%0d[%0d]: got %h expected %h", c, i, v[c], e[c]); end
        end
      end
    end
  endtask

  // ---------------- main sequence / report ----------------
  initial begin
    Reset = 1'b1;
    clear_core(0);
    clear_core(1);
    pref = 0;
    test_reset();
    test_word();
    test_subword();
    test_collision();
    test_rr_store_load();
    test_reset_abort();
    test_random_single();
    test_random_dual();
    repeat (2) @(posedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
